// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one 8N1 UART transmitter among
// NUM_REQ byte sources. After reset it waits one full frame (FLUSH) so a
// transmitter caught mid-frame can finish, then serves requests one byte at a
// time: IDLE -> START -> WAIT (until tx_done) -> GAP -> IDLE.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to add a WAIT watchdog that
// raises the sticky err flag and abandons the byte after TIMEOUT_CYCLES.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int CLOCK_RATE     = 100000000,
   parameter int BAUD_HEDEF     = 115200,
   parameter int TIMEOUT_CYCLES = 20 * (CLOCK_RATE / BAUD_HEDEF)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     ack,
   output logic [2:0]             grant_id,
   output logic                   busy,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_done,
   output logic                   err
);

   localparam int FRAME_CYCLES = 10 * (CLOCK_RATE / BAUD_HEDEF);

   typedef enum logic [2:0] {FLUSH, IDLE, START, WAIT, GAP} state_t;

   state_t               state, state_nxt;
   logic [31:0]          cnt;
   logic                 cnt_run;
   logic [2:0]           rr_ptr;
   logic                 found;
   logic [2:0]           sel;
   logic [7:0]           req_ext;
   logic [63:0]          data_ext;
   logic [NUM_REQ-1:0]   ack_nxt;
   logic                 busy_nxt;
   logic                 tx_start_nxt;
   logic                 timeout_hit;

   // Round-robin pick: first pending request at or above rr_ptr, wrapping.
   always_comb begin
      req_ext  = 8'(req);
      data_ext = 64'(req_data);
      found    = 1'b0;
      sel      = 3'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         logic [2:0] idx;
         idx = 3'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req_ext[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Watchdog expiry in WAIT; constant low when the watchdog is not built.
   always_comb begin
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_hit = (state == WAIT) && !tx_done && (cnt == 32'(TIMEOUT_CYCLES - 1));
      cnt_run     = (state == FLUSH) || (state == WAIT);
`else
      timeout_hit = 1'b0;
      cnt_run     = (state == FLUSH);
`endif
   end

   // State register and per-state cycle counter (cleared on every state change).
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FLUSH;
         cnt   <= 32'd0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            cnt <= 32'd0;
         else if (cnt_run)
            cnt <= cnt + 32'd1;
      end
   end

   // Next-state logic; tx_done is only meaningful in WAIT.
   always_comb begin
      state_nxt = state;
      case (state)
         FLUSH: if (cnt == 32'(FRAME_CYCLES - 1)) state_nxt = IDLE;
         IDLE:  if (found) state_nxt = START;
         START: state_nxt = WAIT;
         WAIT:  if (tx_done || timeout_hit) state_nxt = GAP;
         GAP:   state_nxt = IDLE;
         default: state_nxt = FLUSH;
      endcase
   end

   // Next values of the registered outputs, derived from current/next state.
   always_comb begin
      ack_nxt      = '0;
      if (state == IDLE && found)
         ack_nxt = NUM_REQ'(1) << sel;
      tx_start_nxt = (state == START);
      busy_nxt     = (state_nxt != IDLE);
   end

   // Output and grant registers; data byte is captured only on a grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack      <= '0;
         grant_id <= 3'd0;
         busy     <= 1'b1;
         tx_data  <= 8'h00;
         tx_start <= 1'b0;
         rr_ptr   <= 3'd0;
      end else begin
         ack      <= ack_nxt;
         busy     <= busy_nxt;
         tx_start <= tx_start_nxt;
         if (state == IDLE && found) begin
            tx_data  <= data_ext[{sel, 3'b000} +: 8];
            grant_id <= sel;
            rr_ptr   <= (sel == 3'(NUM_REQ - 1)) ? 3'd0 : sel + 3'd1;
         end
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else if (timeout_hit)
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule
